// File: rtl/seq_detector_prog.sv
// Programmable serial bit-sequence detector (Mealy) with runtime-loadable pattern, length and overlap mode.
// Optional saturating match counter built when MATCH_COUNT_EN is defined.
module seq_detector_prog #(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 8,
    localparam int LW      = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               xin,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LW-1:0]      cfg_len,
    input  logic               cfg_overlap,
    output logic               cfg_err,
    output logic               armed,
    output logic               zout
`ifdef MATCH_COUNT_EN
    ,
    output logic [CNT_W-1:0]   match_count
`endif
);

    if (MAX_LEN < 2 || MAX_LEN > 32 || CNT_W < 1) begin : g_bad_param
        $error("seq_detector_prog: MAX_LEN must be 2..32 and CNT_W >= 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_ARMED} state_t;

    state_t             state, state_n;
    logic [MAX_LEN-1:0] hist, hist_n, pattern, pattern_n;
    logic [MAX_LEN-1:0] mask, cand;
    logic [LW-1:0]      fill, fill_n, len, len_n, len_m1;
    logic               overlap, overlap_n, err_n, cfg_legal, match;

    assign len_m1    = len - LW'(1);
    assign cfg_legal = (cfg_len != '0) && (cfg_len <= LW'(MAX_LEN));
    assign cand      = {hist[MAX_LEN-2:0], xin};

    // Only the low len bits take part in the compare.
    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++)
            mask[i] = (i < int'(len));
    end

    assign match = ((cand ^ pattern) & mask) == '0;
    assign zout  = ~rst & (state == S_ARMED) & in_valid & ~cfg_load & match;

    always_comb begin
        state_n   = state;
        hist_n    = hist;
        fill_n    = fill;
        pattern_n = pattern;
        len_n     = len;
        overlap_n = overlap;
        err_n     = 1'b0;
        if (cfg_load) begin
            // A load always wins over a same-cycle data bit.
            if (cfg_legal) begin
                pattern_n = cfg_pattern;
                len_n     = cfg_len;
                overlap_n = cfg_overlap;
                hist_n    = '0;
                fill_n    = '0;
                state_n   = (cfg_len == LW'(1)) ? S_ARMED : S_FILL;
            end else begin
                err_n = 1'b1;
            end
        end else if (in_valid) begin
            case (state)
                S_FILL: begin
                    hist_n = cand;
                    fill_n = fill + LW'(1);
                    if (fill_n == len_m1)
                        state_n = S_ARMED;
                end
                S_ARMED: begin
                    hist_n = cand;
                    if (match && !overlap) begin
                        hist_n  = '0;
                        fill_n  = '0;
                        state_n = (len == LW'(1)) ? S_ARMED : S_FILL;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            hist    <= '0;
            fill    <= '0;
            pattern <= '0;
            len     <= '0;
            overlap <= 1'b0;
            cfg_err <= 1'b0;
            armed   <= 1'b0;
        end else begin
            state   <= state_n;
            hist    <= hist_n;
            fill    <= fill_n;
            pattern <= pattern_n;
            len     <= len_n;
            overlap <= overlap_n;
            cfg_err <= err_n;
            armed   <= (state_n == S_ARMED);
        end
    end

`ifdef MATCH_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            match_count <= '0;
        else if (cfg_load && cfg_legal)
            match_count <= '0;
        else if (zout && !(&match_count))
            match_count <= match_count + CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed table-driven bench for seq_detector_prog, plus hand-written reset and counter sequences.
module tb_seq_detector_prog;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, xin, cfg_load, cfg_overlap;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_err, armed, zout;
`ifdef MATCH_COUNT_EN
    logic [1:0] match_count;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seq_detector_prog #(.MAX_LEN(8), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .xin(xin),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cfg_err(cfg_err), .armed(armed), .zout(zout)
`ifdef MATCH_COUNT_EN
        , .match_count(match_count)
`endif
    );

    typedef struct {
        logic       ld;
        logic [7:0] pat;
        logic [3:0] len;
        logic       ov, v, x;
        logic       z, a, e;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic ld, logic [7:0] pat, logic [3:0] len, logic ov,
                                logic v, logic x, logic z, logic a, logic e);
        vec_t t;
        t.ld = ld; t.pat = pat; t.len = len; t.ov = ov; t.v = v; t.x = x;
        t.z = z; t.a = a; t.e = e;
        vecs.push_back(t);
    endfunction

    // bit shorthand: valid data bit with expected zout/armed/cfg_err
    function automatic void bit_(logic v, logic x, logic z, logic a, logic e);
        add(1'b0, 8'h00, 4'd0, 1'b0, v, x, z, a, e);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ld, input logic [7:0] pat, input logic [3:0] len,
                         input logic ov, input logic v, input logic x);
        cfg_load = ld; cfg_pattern = pat; cfg_len = len; cfg_overlap = ov;
        in_valid = v; xin = x;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 8'h00, 4'd0, 0, 0, 0);
        #2;
        chk("reset_armed", armed, 0);
        chk("reset_err", cfg_err, 0);
        chk("reset_zout", zout, 0);
`ifdef MATCH_COUNT_EN
        chk("reset_count", match_count, 0);
`endif
        #10 rst = 1'b0;
        tick();

        // T1: overlap, 1011 stream 1,0,1,1,0,1,1
        add(1, 8'h0B, 4'd4, 1, 0, 0, 0, 0, 0);
        bit_(1, 1, 0, 0, 0); bit_(1, 0, 0, 0, 0); bit_(1, 1, 0, 0, 0); bit_(1, 1, 1, 1, 0);
        bit_(1, 0, 0, 1, 0); bit_(1, 1, 0, 1, 0); bit_(1, 1, 1, 1, 0);
        // T2: non-overlap, same stream
        add(1, 8'h0B, 4'd4, 0, 0, 0, 0, 1, 0);
        bit_(1, 1, 0, 0, 0); bit_(1, 0, 0, 0, 0); bit_(1, 1, 0, 0, 0); bit_(1, 1, 1, 1, 0);
        bit_(1, 0, 0, 0, 0); bit_(1, 1, 0, 0, 0); bit_(1, 1, 0, 0, 0);
        // T3: illegal lengths 0 and 9, old pattern kept
        add(1, 8'hFF, 4'd0, 1, 0, 0, 0, 1, 0);
        add(1, 8'hFF, 4'd9, 1, 0, 0, 0, 1, 1);
        bit_(0, 0, 0, 1, 1); bit_(0, 0, 0, 1, 0);
        bit_(1, 1, 0, 1, 0); bit_(1, 0, 0, 1, 0); bit_(1, 1, 0, 1, 0); bit_(1, 1, 1, 1, 0);
        // T4: gaps between bits (xin=1 in gaps)
        add(1, 8'h0B, 4'd4, 1, 0, 0, 0, 0, 0);
        bit_(1, 1, 0, 0, 0); bit_(0, 1, 0, 0, 0); bit_(1, 0, 0, 0, 0); bit_(0, 1, 0, 0, 0);
        bit_(1, 1, 0, 0, 0); bit_(0, 1, 0, 1, 0); bit_(1, 1, 1, 1, 0); bit_(0, 1, 0, 1, 0);
        // load + valid same cycle: xin discarded; upper pattern bits don't-care
        add(1, 8'hAB, 4'd2, 1, 1, 1, 0, 1, 0);
        bit_(1, 1, 0, 0, 0); bit_(1, 1, 1, 1, 0); bit_(1, 1, 1, 1, 0);
        add(1, 8'hAB, 4'd2, 1, 1, 1, 0, 1, 0);
        bit_(1, 1, 0, 0, 0);
        // len=1, non-overlap stays armed
        add(1, 8'h01, 4'd1, 0, 0, 0, 0, 1, 0);
        bit_(1, 1, 1, 1, 0); bit_(1, 0, 0, 1, 0); bit_(1, 1, 1, 1, 0);
        // len=MAX_LEN, pattern 1100_1010
        add(1, 8'hCA, 4'd8, 0, 0, 0, 0, 1, 0);
        bit_(1, 1, 0, 0, 0); bit_(1, 1, 0, 0, 0); bit_(1, 0, 0, 0, 0); bit_(1, 0, 0, 0, 0);
        bit_(1, 1, 0, 0, 0); bit_(1, 0, 0, 0, 0); bit_(1, 1, 0, 0, 0); bit_(1, 0, 1, 1, 0);
        bit_(1, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].ld, vecs[i].pat, vecs[i].len, vecs[i].ov, vecs[i].v, vecs[i].x);
            @(negedge clk);
            chk($sformatf("v%0d_zout", i), zout, vecs[i].z);
            chk($sformatf("v%0d_armed", i), armed, vecs[i].a);
            chk($sformatf("v%0d_err", i), cfg_err, vecs[i].e);
            tick();
        end

        // T5: async reset mid-stream
        drive(1, 8'h0B, 4'd4, 1, 0, 0); tick();
        drive(0, 8'h00, 4'd0, 0, 1, 1); tick();
        drive(0, 8'h00, 4'd0, 0, 1, 0); tick();
        drive(0, 8'h00, 4'd0, 0, 1, 1); tick();
        drive(0, 8'h00, 4'd0, 0, 1, 1);
        #1;
        chk("t5_pre_zout", zout, 1);
        chk("t5_pre_armed", armed, 1);
        rst = 1'b1;
        #1;
        chk("t5_rst_zout", zout, 0);
        chk("t5_rst_armed", armed, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(0, 8'h00, 4'd0, 0, 1, 1);
            @(negedge clk);
            chk($sformatf("t5_idle%0d_zout", k), zout, 0);
            chk($sformatf("t5_idle%0d_armed", k), armed, 0);
            tick();
        end
        drive(1, 8'h01, 4'd1, 1, 0, 0); tick();
        drive(0, 8'h00, 4'd0, 0, 1, 1);
        @(negedge clk);
        chk("t5_reload_zout", zout, 1);
        tick();

`ifdef MATCH_COUNT_EN
        // T6: saturating counter, CNT_W=2
        drive(1, 8'h01, 4'd1, 1, 0, 0); tick();
        chk("t6_load_count", match_count, 0);
        for (int k = 0; k < 6; k++) begin
            drive(0, 8'h00, 4'd0, 0, 1, 1);
            tick();
            chk($sformatf("t6_count%0d", k), match_count, (k < 2) ? k + 1 : 3);
        end
        drive(1, 8'h01, 4'd0, 1, 0, 0); tick();
        chk("t6_illegal_count", match_count, 3);
        drive(1, 8'h01, 4'd1, 1, 0, 0); tick();
        chk("t6_clear_count", match_count, 0);
`endif

        drive(0, 8'h00, 4'd0, 0, 0, 0);
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
